// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter: round-robin arbiter that shares one downstream resource
// among N requesters. Once a requester is granted, it keeps the grant until it
// drops its request or until MAX_HOLD consecutive cycles have passed.
//
// Ports:
//   ck       clock; all state changes on the rising edge
//   rst      synchronous, active-high reset
//   req      request vector; bit i belongs to requester i
//   gnt      registered grant, one-hot or all-zero
//   gnt_vld  registered; high exactly when gnt != 0
//   gnt_idx  registered index of the current owner; 0 when there is no grant
//   any_req  combinational OR of req, used for upstream wake-up
module rr_req_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx,
    output logic          any_req
);

    // The hold counter only has to reach MAX_HOLD. When MAX_HOLD is 0
    // (unlimited hold), the counter is 1 bit wide and sits at its saturation value.
    localparam int unsigned HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t         state_q;
    logic [IW-1:0]  ptr_q;
    logic [HW-1:0]  hold_q;
    logic [N-1:0]   gnt_q;
    logic           gnt_vld_q;
    logic [IW-1:0]  gnt_idx_q;

    logic           win_found_d;
    logic [IW-1:0]  win_idx_d;
    int unsigned    scan_pos;
    logic [N-1:0]   scan_sh;
    logic [N-1:0]   own_sh;
    logic           owner_req;
    logic           hold_limit;
    logic [IW-1:0]  ptr_inc;

    // Wrap-around priority scan: ptr, ptr+1, ... N-1, 0, ...; the first requester found wins.
    always_comb begin
        win_found_d = 1'b0;
        win_idx_d   = '0;
        scan_pos    = 0;
        scan_sh     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_pos = 32'(ptr_q) + k;
            if (scan_pos >= N) begin
                scan_pos = scan_pos - N;
            end
            scan_sh = req >> scan_pos;
            if (!win_found_d && scan_sh[0]) begin
                win_found_d = 1'b1;
                win_idx_d   = IW'(scan_pos);
            end
        end
    end

    // Request bit of the current owner, plus the pointer that takes effect on release.
    assign own_sh     = req >> gnt_idx_q;
    assign owner_req  = own_sh[0];
    assign hold_limit = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
    assign ptr_inc    = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + IW'(1);

    // Arbitration state machine. All outputs are registered here.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found_d) begin
                        gnt_q     <= N'(1) << win_idx_d;
                        gnt_idx_q <= win_idx_d;
                        gnt_vld_q <= 1'b1;
                        hold_q    <= HW'(1);
                        state_q   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req || hold_limit) begin
                        // Release the grant. A forced release also inserts a one-cycle GAP.
                        gnt_q     <= '0;
                        gnt_vld_q <= 1'b0;
                        gnt_idx_q <= '0;
                        hold_q    <= '0;
                        ptr_q     <= ptr_inc;
                        state_q   <= owner_req ? ST_GAP : ST_IDLE;
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_idx = gnt_idx_q;
    assign any_req = |req;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter. It runs two instances side by side:
//   A: N=4, MAX_HOLD=16
//   B: N=5, MAX_HOLD=3
// Both instances are compared every cycle against an owner/pointer model.
// A set of literal expectations on instance A pins that model down.
module tb_rr_req_arbiter;

    localparam int unsigned NA  = 4;
    localparam int unsigned HA  = 16;
    localparam int unsigned IWA = 2;
    localparam int unsigned NB  = 5;
    localparam int unsigned HB  = 3;
    localparam int unsigned IWB = 3;

    logic           ck = 1'b0;
    logic           rst_a, rst_b;
    logic [NA-1:0]  req_a, gnt_a;
    logic [NB-1:0]  req_b, gnt_b;
    logic           gnt_vld_a, gnt_vld_b, any_req_a, any_req_b;
    logic [IWA-1:0] gnt_idx_a;
    logic [IWB-1:0] gnt_idx_b;

    int errors = 0;
    int checks = 0;
    bit rand_phase = 1'b0;

    always #5 ck = ~ck;

    rr_req_arbiter #(.N(NA), .MAX_HOLD(HA)) u_dut_a (
        .ck(ck), .rst(rst_a), .req(req_a), .gnt(gnt_a),
        .gnt_vld(gnt_vld_a), .gnt_idx(gnt_idx_a), .any_req(any_req_a)
    );

    rr_req_arbiter #(.N(NB), .MAX_HOLD(HB)) u_dut_b (
        .ck(ck), .rst(rst_b), .req(req_b), .gnt(gnt_b),
        .gnt_vld(gnt_vld_b), .gnt_idx(gnt_idx_b), .any_req(any_req_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the current owner (-1 when there is none), a pending gap cycle,
    // the scan start pointer, and how many cycles the owner has held the grant.
    typedef struct {
        int owner;
        bit gap;
        int ptr;
        int hold;
    } mdl_t;

    function automatic mdl_t mstep(input mdl_t m, input int n, input int maxh,
                                   input bit r_rst, input logic [15:0] r);
        mdl_t x = m;
        if (r_rst) begin
            x.owner = -1; x.gap = 1'b0; x.ptr = 0; x.hold = 0;
        end else if (m.owner >= 0) begin
            if (!r[m.owner]) begin
                x.ptr = (m.owner + 1) % n; x.owner = -1;
            end else if (maxh != 0 && m.hold >= maxh) begin
                x.ptr = (m.owner + 1) % n; x.owner = -1; x.gap = 1'b1;
            end else begin
                x.hold = m.hold + 1;
            end
        end else if (m.gap) begin
            x.gap = 1'b0;
        end else begin
            for (int k = 0; k < n; k++) begin
                if (x.owner < 0 && r[(m.ptr + k) % n]) begin
                    x.owner = (m.ptr + k) % n;
                    x.hold  = 1;
                end
            end
        end
        return x;
    endfunction

    task automatic check_inst(input string tag, input mdl_t m, input logic [31:0] g,
                              input logic v, input logic [31:0] idx,
                              input logic ar, input logic [31:0] rq);
        logic [31:0] eg;
        logic [31:0] sh;
        eg = (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0;
        sh = g >> idx;
        chk({tag, " gnt"},     g,              eg);
        chk({tag, " gnt_vld"}, 32'(v),         32'(m.owner >= 0));
        chk({tag, " gnt_idx"}, idx,            (m.owner >= 0) ? 32'(m.owner) : 32'd0);
        chk({tag, " onehot"},  32'($countones(g) <= 1), 32'd1);
        chk({tag, " vld_or"},  32'(v),         32'(|g));
        chk({tag, " idx_bit"}, 32'(sh[0]),     32'(v));
        chk({tag, " any_req"}, 32'(ar),        32'(|rq));
    endtask

    mdl_t ma, mb;
    bit   va = 1'b0, vb = 1'b0;
    logic [15:0] ra_s, rb_s;
    logic        sra, srb;
    int   wait_a [NA];
    int   wait_b [NB];
    int   maxw_a = 0, maxw_b = 0;
    bit   seen_a [NA];
    bit   seen_b [NB];

    // Single compare process: sample the inputs at the edge, advance the model, check just after the edge.
    always @(posedge ck) begin
        ra_s = 16'(req_a); rb_s = 16'(req_b);
        sra = rst_a;       srb = rst_b;
        #1;
        ma = mstep(ma, NA, HA, sra, ra_s);
        mb = mstep(mb, NB, HB, srb, rb_s);
        if (sra) va = 1'b1;
        if (srb) vb = 1'b1;
        if (va) begin
            check_inst("A", ma, 32'(gnt_a), gnt_vld_a, 32'(gnt_idx_a), any_req_a, 32'(req_a));
            for (int i = 0; i < NA; i++) begin
                if (sra || !ra_s[i] || gnt_a[i]) wait_a[i] = 0;
                else wait_a[i]++;
                if (wait_a[i] > maxw_a) maxw_a = wait_a[i];
                if (rand_phase && gnt_a[i]) seen_a[i] = 1'b1;
            end
        end
        if (vb) begin
            check_inst("B", mb, 32'(gnt_b), gnt_vld_b, 32'(gnt_idx_b), any_req_b, 32'(req_b));
            for (int i = 0; i < NB; i++) begin
                if (srb || !rb_s[i] || gnt_b[i]) wait_b[i] = 0;
                else wait_b[i]++;
                if (wait_b[i] > maxw_b) maxw_b = wait_b[i];
                if (rand_phase && gnt_b[i]) seen_b[i] = 1'b1;
            end
        end
    end

    always @(posedge ck) begin
        if (va) assert (!$isunknown(req_a)) else $error("X on req_a");
        if (vb) assert (!$isunknown(req_b)) else $error("X on req_b");
    end

    // Apply the inputs at the current negedge, then move on to the next negedge.
    task automatic step(input logic r, input logic [NA-1:0] q);
        rst_a = r; req_a = q;
        rst_b = r; req_b = '0;
        @(negedge ck);
    endtask

    task automatic lit(input string name, input logic [NA-1:0] eg, input logic [IWA-1:0] ei);
        chk({name, " gnt"},     32'(gnt_a),     32'(eg));
        chk({name, " gnt_idx"}, 32'(gnt_idx_a), 32'(ei));
        chk({name, " gnt_vld"}, 32'(gnt_vld_a), 32'(|eg));
    endtask

    initial begin
        for (int i = 0; i < NA; i++) begin wait_a[i] = 0; seen_a[i] = 1'b0; end
        for (int i = 0; i < NB; i++) begin wait_b[i] = 0; seen_b[i] = 1'b0; end

        // Reset with all requests high; requester 0 wins first after reset.
        step(1'b1, 4'b1111); lit("t1 rst0", 4'b0000, 2'd0);
        step(1'b1, 4'b1111); lit("t1 rst1", 4'b0000, 2'd0);
        step(1'b0, 4'b1111); lit("t1 first", 4'b0001, 2'd0);

        // From ptr=0, 1010 grants requester 1. After it releases, requester 3 is granted after a one-cycle gap.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1010); lit("t2 gnt1", 4'b0010, 2'd1);
        step(1'b0, 4'b1000); lit("t2 gap",  4'b0000, 2'd0);
        step(1'b0, 4'b1000); lit("t2 gnt3", 4'b1000, 2'd3);

        // Requester 0 does not preempt requester 3. When 3 releases, ptr wraps to 0.
        step(1'b0, 4'b1001); lit("t4 hold3", 4'b1000, 2'd3);
        step(1'b0, 4'b0001); lit("t4 rel",   4'b0000, 2'd0);
        step(1'b0, 4'b0001); lit("t4 gnt0",  4'b0001, 2'd0);

        // Sole requester 2 holds for 16 cycles, is released for 2 cycles, then is granted again.
        step(1'b1, 4'b0000);
        for (int i = 1; i <= 19; i++) begin
            step(1'b0, 4'b0100);
            if (i <= 16 || i == 19) lit($sformatf("t3 c%0d", i), 4'b0100, 2'd2);
            else                    lit($sformatf("t3 c%0d", i), 4'b0000, 2'd0);
        end

        // Reset while requester 2 owns the grant, then resume from ptr=0.
        step(1'b1, 4'b0110); lit("t5 rst", 4'b0000, 2'd0);
        step(1'b0, 4'b0110); lit("t5 gnt1", 4'b0010, 2'd1);

        // Random phase: sticky request bits with occasional resets, on both instances.
        rand_phase = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NA; i++)
                if ($urandom_range(7) == 0) req_a[i] = ~req_a[i];
            for (int i = 0; i < NB; i++)
                if ($urandom_range(7) == 0) req_b[i] = ~req_b[i];
            rst_a = ($urandom_range(999) == 0);
            rst_b = ($urandom_range(999) == 0);
            @(negedge ck);
        end
        rst_a = 1'b0; rst_b = 1'b0;

        chk("A wait bound", 32'(maxw_a <= (NA - 1) * (HA + 2) + 1), 32'd1);
        chk("B wait bound", 32'(maxw_b <= (NB - 1) * (HB + 2) + 1), 32'd1);
        for (int i = 0; i < NA; i++) chk($sformatf("A seen %0d", i), 32'(seen_a[i]), 32'd1);
        for (int i = 0; i < NB; i++) chk($sformatf("B seen %0d", i), 32'(seen_b[i]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
